vga_timing_gen: RTL and testbench

- Generates 640x480@60 VGA raster timing from the 50 MHz system clock.
- Drives the pixel coordinates and active-region flag consumed by the object renderers, and takes back their combinational 24-bit colour.
- Registers that colour together with the sync and blank signals into the DAC/connector pins.
- Also produces a once-per-frame tick that object renderers use as their motion update strobe.

---
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 tb/tb_vga_timing_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator: pixel-enable divider, h/v counters,
// sync/blank decode and a registered output stage for the DAC pins.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] vga_color,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        active_pixels,
  output logic        pix_en,
  output logic        frame_tick,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_M = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic [DW-1:0] div_next;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          h_wrap;
  logic          hs_n;
  logic          vs_n;

  // pix_en and VGA_CLK are decoded from the next divider value so both are
  // clean registered outputs aligned with the divider phase they describe.
  always_comb begin
    div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div     <= '0;
      pix_en  <= 1'b0;
      VGA_CLK <= 1'b0;
    end else begin
      div     <= div_next;
      pix_en  <= (div_next == DIV_LAST);
      VGA_CLK <= (div_next >= DIV_HALF);
    end
  end

  assign h_wrap = (h_cnt == H_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_en && h_wrap && (v_cnt == V_ACT_M);
      if (pix_en) begin
        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign x             = h_cnt;
  assign y             = v_cnt;
  assign active_pixels = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_n          = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_n          = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign VGA_SYNC_N    = 1'b0;

  // Sync, blank and colour share one register stage so they stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pix_en) begin
      VGA_HS      <= hs_n;
      VGA_VS      <= vs_n;
      VGA_BLANK_N <= active_pixels;
      VGA_R       <= active_pixels ? vga_color[23:16] : 8'h00;
      VGA_G       <= active_pixels ? vga_color[15:8]  : 8'h00;
      VGA_B       <= active_pixels ? vga_color[7:0]   : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster (25x13 totals) so
// several whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 6,  VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  logic        clk;
  logic        rst;
  logic [23:0] vga_color;
  logic [9:0]  x, y;
  logic        active_pixels, pix_en, frame_tick;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .vga_color(vga_color), .x(x), .y(y),
    .active_pixels(active_pixels), .pix_en(pix_en), .frame_tick(frame_tick),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic [23:0] rgb;
    logic        tick;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   mode  = 0;
  int   n     = 0;
  int   ticks = 0;

  function automatic logic [23:0] pattern(int m, int px, int py);
    case (m)
      0:       return 24'hFFFFFF;
      1:       return (px == 5) ? 24'h123456 : 24'h000000;
      2:       return {8'(px * 3), 8'(py * 7), 8'hA5};
      default: return 24'h000000;
    endcase
  endfunction

  always_comb vga_color = pattern(mode, int'(x), int'(y));

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Producer: on each pix_en phase, check coordinates against a pixel-index
  // model and queue the pins expected one pixel later.
  always @(negedge clk) begin
    exp_t e;
    int   px, py;
    if (!rst) begin
      n = 0;
    end else if (pix_en) begin
      px = n % HT;
      py = (n / HT) % VT;
      check_output("x", 32'(x), 32'(px));
      check_output("y", 32'(y), 32'(py));
      check_output("tick_idle", 32'(frame_tick), 0);
      check_output("vga_clk_hi", 32'(VGA_CLK), 1);
      e.blank_n = (px < HA) && (py < VA);
      e.hs      = !((px >= HA + HFP) && (px < HA + HFP + HS));
      e.vs      = !((py >= VA + VFP) && (py < VA + VFP + VS));
      e.rgb     = e.blank_n ? pattern(mode, px, py) : 24'h0;
      e.tick    = (px == HT - 1) && (py == VA - 1);
      q.push_back(e);
      n++;
    end
  end

  // Monitor: one clk after each pix_en edge the pins carry the queued pixel.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      q.delete();
      ticks = 0;
    end else if (!pix_en && q.size() > 0) begin
      e = q.pop_front();
      check_output("hs", 32'(VGA_HS), 32'(e.hs));
      check_output("vs", 32'(VGA_VS), 32'(e.vs));
      check_output("blank_n", 32'(VGA_BLANK_N), 32'(e.blank_n));
      check_output("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, e.rgb});
      check_output("frame_tick", 32'(frame_tick), 32'(e.tick));
      check_output("vga_clk_lo", 32'(VGA_CLK), 0);
      check_output("sync_n", 32'(VGA_SYNC_N), 0);
      if (frame_tick) begin
        check_output("tick_pos", 32'(n), 32'(VA * HT + ticks * HT * VT));
        ticks++;
      end
    end
  end

  task automatic check_reset_values();
    check_output("rst_x", 32'(x), 0);
    check_output("rst_y", 32'(y), 0);
    check_output("rst_pix_en", 32'(pix_en), 0);
    check_output("rst_tick", 32'(frame_tick), 0);
    check_output("rst_vga_clk", 32'(VGA_CLK), 0);
    check_output("rst_hs", 32'(VGA_HS), 1);
    check_output("rst_vs", 32'(VGA_VS), 1);
    check_output("rst_blank_n", 32'(VGA_BLANK_N), 0);
    check_output("rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 0);
  endtask

  // Change the colour pattern only in a non-pix_en phase so the queued
  // expectation and the sampled colour always use the same mode.
  task automatic apply_stimulus(input int m, input int clks);
    do @(negedge clk); while (pix_en);
    mode = m;
    repeat (clks) @(negedge clk);
  endtask

  initial begin
    int t0;
    int budget;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_values();
    @(negedge clk);
    #2 rst = 1'b1;

    @(negedge clk);
    check_output("first_pix_en", 32'(pix_en), 1);
    repeat (2) @(negedge clk);
    check_output("x_after_one_pixel", 32'(x), 1);

    t0 = n;
    repeat (100) @(negedge clk);
    check_output("pixel_rate", 32'(n - t0), 50);

    // White for more than one frame, then single-pixel colour, then gradient.
    apply_stimulus(0, 2 * HT * VT);
    apply_stimulus(1, 2 * HT * VT);
    apply_stimulus(2, 2 * HT * VT);
    check_output("ticks_three_frames", 32'(ticks), 3);

    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(x == 10'd8 && y == 10'd3 && pix_en) && budget < 2000);
    check_output("reach_mid_frame", 32'(budget < 2000), 1);
    #2 rst = 1'b0;
    #1 check_reset_values();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;

    apply_stimulus(0, 800);
    check_output("ticks_after_reset", 32'(ticks), 1);
    check_output("queue_drained", 32'(q.size() <= 1), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
